// File: rtl/sdpram_bw.sv
// Simple dual-port RAM with per-byte write enables, 1..3 cycle pipelined read
// and selectable read-during-write result. Optional clear-on-reset: SDPRAM_INIT_CLEAR_EN.
module sdpram_bw #(
  parameter int DATA_WIDTH   = 32,
  parameter int BYTE_WIDTH   = 8,
  parameter int WORD_DEPTH   = 4,
  parameter int READ_LATENCY = 1,
  parameter int RDW_MODE     = 0
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [WORD_DEPTH-1:0]               addra,
  input  logic [DATA_WIDTH-1:0]               dina,
  input  logic [DATA_WIDTH/BYTE_WIDTH-1:0]    wea,
  input  logic                                ena,
  input  logic [WORD_DEPTH-1:0]               addrb,
  input  logic                                enb,
  output logic [DATA_WIDTH-1:0]               doutb,
  output logic                                doutb_valid,
  output logic                                init_busy
);

  localparam int NUM_BYTES = DATA_WIDTH / BYTE_WIDTH;
  localparam int DEPTH     = 2 ** WORD_DEPTH;

  if ((READ_LATENCY < 1) || (READ_LATENCY > 3)) begin : g_bad_latency
    $fatal(1, "sdpram_bw: READ_LATENCY must be 1..3");
  end
  if ((DATA_WIDTH % BYTE_WIDTH) != 0) begin : g_bad_width
    $fatal(1, "sdpram_bw: DATA_WIDTH must be a multiple of BYTE_WIDTH");
  end

  logic [DATA_WIDTH-1:0] mem_r [DEPTH];
  logic [DATA_WIDTH-1:0] pipe_data_r [READ_LATENCY];
  logic [READ_LATENCY-1:0] pipe_vld_r;

  logic                  ready_s;
  logic                  clr_we_s;
  logic [WORD_DEPTH-1:0] clr_addr_s;
  logic                  wr_s;
  logic                  rd_s;
  logic [DATA_WIDTH-1:0] rd_word_s;

`ifdef SDPRAM_INIT_CLEAR_EN
  typedef enum logic [0:0] {
    ST_CLEAR = 1'b0,
    ST_READY = 1'b1
  } state_t;

  state_t                state_r;
  logic [WORD_DEPTH-1:0] clr_cnt_r;
  logic                  init_busy_r;

  // Clear sequencer: sweeps every address once after reset, then idles in READY.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_r     <= ST_CLEAR;
      clr_cnt_r   <= '0;
      init_busy_r <= 1'b1;
    end else begin
      case (state_r)
        ST_CLEAR: begin
          clr_cnt_r <= clr_cnt_r + 1'b1;
          if (clr_cnt_r == {WORD_DEPTH{1'b1}}) begin
            state_r     <= ST_READY;
            init_busy_r <= 1'b0;
          end else begin
            state_r     <= ST_CLEAR;
            init_busy_r <= 1'b1;
          end
        end
        ST_READY: begin
          state_r     <= ST_READY;
          init_busy_r <= 1'b0;
        end
        default: begin
          state_r     <= ST_CLEAR;
          clr_cnt_r   <= '0;
          init_busy_r <= 1'b1;
        end
      endcase
    end
  end

  assign ready_s    = (state_r == ST_READY);
  assign clr_we_s   = (state_r == ST_CLEAR);
  assign clr_addr_s = clr_cnt_r;
  assign init_busy  = init_busy_r;
`else
  assign ready_s    = 1'b1;
  assign clr_we_s   = 1'b0;
  assign clr_addr_s = '0;
  assign init_busy  = 1'b0;
`endif

  assign wr_s = ena & (|wea) & ready_s & ~reset;
  assign rd_s = enb & ready_s & ~reset;

  // Read word for the port-B request; bypass merges write lanes on a collision.
  always_comb begin
    rd_word_s = mem_r[addrb];
    if ((RDW_MODE == 1) && wr_s && (addra == addrb)) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wea[i]) begin
          rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end else begin
          rd_word_s[i*BYTE_WIDTH +: BYTE_WIDTH] = mem_r[addrb][i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end else begin
      rd_word_s = mem_r[addrb];
    end
  end

  // Storage array: clear sweep has priority over user writes; no reset state.
  always_ff @(posedge clk) begin
    if (!reset && clr_we_s) begin
      mem_r[clr_addr_s] <= '0;
    end else if (wr_s) begin
      for (int i = 0; i < NUM_BYTES; i++) begin
        if (wea[i]) begin
          mem_r[addra][i*BYTE_WIDTH +: BYTE_WIDTH] <= dina[i*BYTE_WIDTH +: BYTE_WIDTH];
        end
      end
    end
  end

  // Read pipeline: data stages load only behind a valid so doutb holds between reads.
  always_ff @(posedge clk) begin
    if (reset) begin
      pipe_vld_r <= '0;
      for (int k = 0; k < READ_LATENCY; k++) begin
        pipe_data_r[k] <= '0;
      end
    end else begin
      pipe_vld_r[0] <= rd_s;
      if (rd_s) begin
        pipe_data_r[0] <= rd_word_s;
      end
      for (int k = 1; k < READ_LATENCY; k++) begin
        pipe_vld_r[k] <= pipe_vld_r[k-1];
        if (pipe_vld_r[k-1]) begin
          pipe_data_r[k] <= pipe_data_r[k-1];
        end
      end
    end
  end

  assign doutb       = pipe_data_r[READ_LATENCY-1];
  assign doutb_valid = pipe_vld_r[READ_LATENCY-1];

endmodule

// File: tb/tb_sdpram_bw.sv
// Scoreboard bench for sdpram_bw: three instances (latency 1/2/3, both collision
// modes) share one random stimulus stream and are checked against a word-level model.
module tb_sdpram_bw;

  localparam int DW    = 32;
  localparam int BW    = 8;
  localparam int WD    = 4;
  localparam int NB    = DW / BW;
  localparam int DEPTH = 2 ** WD;
  localparam int NDUT  = 3;
  localparam int RL_A  [NDUT] = '{1, 2, 3};
  localparam int RDW_A [NDUT] = '{0, 1, 0};
`ifdef SDPRAM_INIT_CLEAR_EN
  localparam bit CLR = 1'b1;
`else
  localparam bit CLR = 1'b0;
`endif

  typedef struct {
    logic [DW-1:0] d;
    int            at;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          reset = 1'b1;
  logic          ena = 1'b0, enb = 1'b0;
  logic [WD-1:0] addra = '0, addrb = '0;
  logic [DW-1:0] dina = '0;
  logic [NB-1:0] wea = '0;

  logic [DW-1:0] dout [NDUT];
  logic          vld  [NDUT];
  logic          busy [NDUT];

  sdpram_bw #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .WORD_DEPTH(WD), .READ_LATENCY(1), .RDW_MODE(0)) dut0 (
    .clk(clk), .reset(reset), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(dout[0]), .doutb_valid(vld[0]), .init_busy(busy[0]));
  sdpram_bw #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .WORD_DEPTH(WD), .READ_LATENCY(2), .RDW_MODE(1)) dut1 (
    .clk(clk), .reset(reset), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(dout[1]), .doutb_valid(vld[1]), .init_busy(busy[1]));
  sdpram_bw #(.DATA_WIDTH(DW), .BYTE_WIDTH(BW), .WORD_DEPTH(WD), .READ_LATENCY(3), .RDW_MODE(0)) dut2 (
    .clk(clk), .reset(reset), .addra(addra), .dina(dina), .wea(wea), .ena(ena),
    .addrb(addrb), .enb(enb), .doutb(dout[2]), .doutb_valid(vld[2]), .init_busy(busy[2]));

  logic [DW-1:0] mem_m [DEPTH];
  exp_t          q [NDUT][$];
  logic [DW-1:0] hold [NDUT];
  int            edge_cnt = 0;
  int            rst_e = -1000;
  bit            started = 1'b0;
  int            errors = 0;
  int            checks = 0;

  function automatic bit ready_at(input int e);
    return !CLR || (e > rst_e + DEPTH);
  endfunction

  // One clock edge with the given inputs, then the reference model's view of that edge.
  task automatic step(input logic r, input logic a_en, input logic [NB-1:0] w,
                      input logic [WD-1:0] aa, input logic [DW-1:0] d,
                      input logic b_en, input logic [WD-1:0] ab);
    logic [DW-1:0] nw;
    exp_t          e;
    reset = r; ena = a_en; wea = w; addra = aa; dina = d; enb = b_en; addrb = ab;
    @(posedge clk);
    edge_cnt++;
    #1;
    if (r) begin
      started = 1'b1;
      for (int k = 0; k < NDUT; k++) begin
        q[k].delete();
        hold[k] = '0;
      end
      if (CLR) begin
        rst_e = edge_cnt;
        for (int a = 0; a < DEPTH; a++) mem_m[a] = '0;
      end
    end else if (ready_at(edge_cnt)) begin
      nw = mem_m[aa];
      for (int i = 0; i < NB; i++)
        if (w[i]) nw[i*BW +: BW] = d[i*BW +: BW];
      if (b_en) begin
        for (int k = 0; k < NDUT; k++) begin
          e.d  = (RDW_A[k] == 1 && a_en && aa == ab) ? nw : mem_m[ab];
          e.at = edge_cnt + RL_A[k] - 1;
          q[k].push_back(e);
        end
      end
      if (a_en) mem_m[aa] = nw;
    end
  endtask

  task automatic idle();
    step(1'b0, 1'b0, '0, '0, '0, 1'b0, '0);
  endtask

  task automatic wr(input logic [WD-1:0] a, input logic [DW-1:0] d, input logic [NB-1:0] w);
    step(1'b0, 1'b1, w, a, d, 1'b0, '0);
  endtask

  task automatic rd(input logic [WD-1:0] a);
    step(1'b0, 1'b0, '0, '0, '0, 1'b1, a);
  endtask

  // Reset, then idle through any clear period while attempting reads that must be ignored.
  task automatic do_reset();
    step(1'b1, 1'b1, '1, 4'd1, 32'h12345678, 1'b1, 4'd1);
    while (!ready_at(edge_cnt + 1))
      step(1'b0, 1'b1, '1, WD'($urandom_range(0, DEPTH - 1)), 32'hFFFFFFFF,
           1'b1, WD'($urandom_range(0, DEPTH - 1)));
  endtask

  // Monitor: pops expected words when valid, otherwise checks doutb holds.
  always @(negedge clk) begin
    if (started) begin
      for (int k = 0; k < NDUT; k++) begin
        exp_t e;
        logic exp_busy;
        exp_busy = CLR && (edge_cnt >= rst_e) && (edge_cnt < rst_e + DEPTH);
        checks++;
        if (busy[k] !== exp_busy) begin
          errors++;
          $display("FAIL init_busy dut%0d edge %0d: got %b want %b", k, edge_cnt, busy[k], exp_busy);
        end
        checks++;
        if (vld[k] === 1'b1) begin
          if (q[k].size() == 0) begin
            errors++;
            $display("FAIL unexpected_valid dut%0d edge %0d: got data %h, no read pending", k, edge_cnt, dout[k]);
          end else begin
            e = q[k].pop_front();
            if (dout[k] !== e.d || edge_cnt != e.at) begin
              errors++;
              $display("FAIL read_data dut%0d: got %h at edge %0d want %h at edge %0d",
                       k, dout[k], edge_cnt, e.d, e.at);
            end
            hold[k] = e.d;
          end
        end else if (vld[k] !== 1'b0 || dout[k] !== hold[k]) begin
          errors++;
          $display("FAIL hold dut%0d edge %0d: got valid %b data %h want valid 0 data %h",
                   k, edge_cnt, vld[k], dout[k], hold[k]);
        end
      end
    end
  end

  initial begin
    do_reset();
    for (int a = 0; a < DEPTH; a++) wr(WD'(a), 32'hA0 + DW'(a), 4'hF);
    // Back-to-back reads of A0..A3
    for (int a = 0; a < 4; a++) rd(WD'(a));
    idle(); idle(); idle();
    // Full write then read
    wr(4'd3, 32'hDEADBEEF, 4'hF);
    rd(4'd3);
    idle(); idle(); idle();
    // Byte lanes
    wr(4'd5, 32'h11223344, 4'hF);
    wr(4'd5, 32'hAABBCCDD, 4'b0101);
    rd(4'd5);
    // Partial-enable no-op and collision at address 2
    wr(4'd2, 32'h00000000, 4'hF);
    step(1'b0, 1'b1, 4'b0000, 4'd2, 32'hCAFEF00D, 1'b1, 4'd2);
    step(1'b0, 1'b1, 4'b0011, 4'd2, 32'hFFFFFFFF, 1'b1, 4'd2);
    rd(4'd2);
    idle(); idle(); idle();
    // Reset with a read in flight
    wr(4'd7, 32'h77777777, 4'hF);
    rd(4'd7);
    do_reset();
    idle(); idle();
    for (int a = 0; a < DEPTH; a++) rd(WD'(a));
    idle(); idle(); idle();
    // Randomised traffic with collision bias and occasional resets
    for (int n = 0; n < 600; n++) begin
      logic [WD-1:0] aa;
      logic [WD-1:0] ab;
      aa = WD'($urandom_range(0, DEPTH - 1));
      ab = ($urandom_range(0, 2) == 0) ? aa : WD'($urandom_range(0, DEPTH - 1));
      if ($urandom_range(0, 99) == 0) begin
        do_reset();
      end else begin
        step(1'b0, 1'($urandom_range(0, 1)), NB'($urandom), aa, DW'($urandom),
             1'($urandom_range(0, 3) != 0), ab);
      end
    end
    for (int n = 0; n < 8; n++) idle();
    for (int k = 0; k < NDUT; k++) begin
      checks++;
      if (q[k].size() != 0) begin
        errors++;
        $display("FAIL drain dut%0d: %0d reads never returned, want 0", k, q[k].size());
      end
    end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: bench did not complete, want completion");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/sdpram_bw.md
Name: sdpram_bw

Overview:
- Parametrised simple dual-port RAM with one write port (A) and one read port (B), a single clock, and a synchronous active-high reset.
- Successor to the team's fixed-width sdpram. Adds per-byte write enables, a configurable pipelined read latency with a valid strobe, and a selectable read-during-write collision mode.
- Used as a generic buffer and register-file primitive across datapath blocks.

Parameters:
- DATA_WIDTH, 32: word width in bits. Must be a multiple of BYTE_WIDTH.
- BYTE_WIDTH, 8: width of one write-enable lane.
- WORD_DEPTH, 4: address width in bits. Memory holds 2**WORD_DEPTH words.
- READ_LATENCY, 1: cycles from read request to data. Legal values 1..3.
- RDW_MODE, 0: same-address read-during-write result. 0 = old data, 1 = new data (bypass).
- Derived: NUM_BYTES = DATA_WIDTH/BYTE_WIDTH.

Ports:
- clk  in  1  single clock, all logic on the rising edge
- reset  in  1  synchronous, active-high reset
- addra  in  WORD_DEPTH  write address
- dina  in  DATA_WIDTH  write data
- wea  in  NUM_BYTES  per-byte write enable; lane i covers dina[i*BYTE_WIDTH +: BYTE_WIDTH]
- ena  in  1  write port enable
- addrb  in  WORD_DEPTH  read address
- enb  in  1  read request
- doutb  out  DATA_WIDTH  read data
- doutb_valid  out  1  one-cycle strobe marking new doutb
- init_busy  out  1  memory-clear in progress (see Optional Feature)

Behaviour:
- Elaboration: illegal READ_LATENCY, or DATA_WIDTH not a multiple of BYTE_WIDTH, triggers $fatal.
- Write: on a rising edge with ena=1, each lane i with wea[i]=1 updates mem[addra] lane i. Other lanes keep their value. ena=1 with wea=0 is a no-op.
- Read accept: a rising edge with enb=1 samples addrb. The word appears on doutb exactly READ_LATENCY edges later, with doutb_valid=1 for that one cycle.
- Pipelining: one read is accepted per cycle, with no stalls and no back-pressure. Back-to-back reads give back-to-back valids, in request order.
- Pipeline stages: each stage holds a data register plus a valid bit. A data register loads only when its incoming valid is 1. doutb therefore holds the last returned word while doutb_valid=0.
- Collision (ena=1, enb=1, addra==addrb, |wea=1, same edge):
  - RDW_MODE=0: the read returns the pre-write word.
  - RDW_MODE=1: the read returns the merged word — enabled lanes from dina, other lanes from the old word.
  - In both modes the memory is updated as for a normal write.
- Address wrap: the full WORD_DEPTH-bit address space is used, so no out-of-range case exists.
- Reset (reset=1 at an edge):
  - All valid bits clear; doutb=0, doutb_valid=0.
  - In-flight reads are discarded and no valid is produced for them.
  - Memory contents are unchanged unless the Optional Feature is enabled.
  - Writes and reads presented on a reset edge are ignored.
- First accepted read: enb sampled on the first edge after reset deasserts.

Optional Feature:
- Macro: SDPRAM_INIT_CLEAR_EN.
- Enabled: a two-state FSM, CLEAR and READY.
  - Reset forces CLEAR with clr_cnt=0.
  - In CLEAR, each edge writes 0 to mem[clr_cnt] and increments clr_cnt.
  - At clr_cnt == 2**WORD_DEPTH-1 the final word is written and the FSM moves to READY.
  - init_busy=1 throughout CLEAR, for exactly 2**WORD_DEPTH cycles after reset deasserts.
  - While init_busy=1, ena and enb are ignored and no valid is produced.
  - Reset during CLEAR restarts clearing from address 0.
- Disabled: no FSM, init_busy tied to 0, memory has no reset state, and the block is ready on the first edge after reset.

Test Plan:
1. Default parameters. Write 0xDEADBEEF to address 3 with wea=4'hF, then read address 3 → doutb=0xDEADBEEF with doutb_valid high exactly 1 cycle after the read edge.
2. Byte enables. Address 5 holds 0x11223344; write dina=0xAABBCCDD with wea=4'b0101 → a read returns 0x11BB33DD.
3. READ_LATENCY=3. Issue 4 back-to-back reads of addresses 0,1,2,3 holding 0xA0..0xA3 → four consecutive valid cycles starting 3 edges after the first request, data in order 0xA0..0xA3.
4. Collision at address 2 (old 0x00000000, write 0xFFFFFFFF, wea=4'b0011) → RDW_MODE=0 returns 0x00000000; RDW_MODE=1 returns 0x0000FFFF. A following read returns 0x0000FFFF in both modes.
5. Reset mid-read. Issue a read with READ_LATENCY=2 and assert reset on the next edge → doutb=0 and no doutb_valid pulse; memory still holds prior data.
6. With SDPRAM_INIT_CLEAR_EN and WORD_DEPTH=4, preload 0x5A in all words, then reset → init_busy high for 16 cycles. A read issued during busy produces no valid. Reads after busy return 0 for all 16 addresses.
